autotype_sequencer: RTL

- Scripted power-on/demo input generator for the retro-computer cores on boards without buttons or keyboard.
- Replaces fixed counter-decoded reset/key pulses with a small writable script: target-reset pulses, single-key presses and timed waits.
- Clocked from the pixel clock; outputs drive the core's n_reset and its onboard key inputs.

---
 rtl/autotype_sequencer.sv | 205 ++++++++++++++++++++
 1 files changed

// File: rtl/autotype_sequencer.sv
// autotype_sequencer: scripted reset/key-press generator for retro-computer cores on boards
// without buttons or a keyboard. A small writable script of RESET pulses, single key presses
// and timed waits runs once on start (or automatically after reset when AUTOSTART=1).
//
// Ports:
//   clk_i          system (pixel) clock
//   n_reset_i      synchronous active-low reset
//   start_i        one-cycle pulse, run the script from entry 0 (ignored while busy)
//   abort_i        one-cycle pulse, stop and release all outputs (wins over start_i)
//   script_we_i    script write strobe, accepted in any state and during reset
//   script_addr_i  script write address
//   script_data_i  script entry {op[1:0], arg[ARG_W-1:0]}; op 00 END, 01 PRESS, 10 WAIT, 11 RESET
//   sys_n_reset_o  active-low reset to the target core
//   keys_o         one-hot key outputs, active high
//   busy_o         script executing
//   done_o         last run finished (held until start/abort; one-cycle pulse per pass in loop mode)
//
// Build option: define AUTOTYPE_LOOP_EN to loop the script forever instead of stopping in DONE.

module autotype_sequencer #(
    parameter int unsigned STEP_BITS  = 23,
    parameter int unsigned NUM_KEYS   = 8,
    parameter int unsigned ARG_W      = 6,
    parameter int unsigned SCRIPT_LEN = 16,
    parameter bit          AUTOSTART  = 1'b1,
    parameter string       INIT_FILE  = ""
) (
    input  logic                          clk_i,
    input  logic                          n_reset_i,
    input  logic                          start_i,
    input  logic                          abort_i,
    input  logic                          script_we_i,
    input  logic [$clog2(SCRIPT_LEN)-1:0] script_addr_i,
    input  logic [ARG_W+1:0]              script_data_i,
    output logic                          sys_n_reset_o,
    output logic [NUM_KEYS-1:0]           keys_o,
    output logic                          busy_o,
    output logic                          done_o
);

    localparam int unsigned AW = $clog2(SCRIPT_LEN);
    localparam logic [AW-1:0] LastPc = AW'(SCRIPT_LEN - 1);

    localparam logic [1:0] OpEnd   = 2'b00;
    localparam logic [1:0] OpPress = 2'b01;
    localparam logic [1:0] OpWait  = 2'b10;
    localparam logic [1:0] OpReset = 2'b11;

    typedef enum logic [2:0] {
        StIdle, StFetch, StPressHold, StPressGap, StWait, StRst, StDone
    } state_e;

    logic [ARG_W+1:0]     mem_q [SCRIPT_LEN];
    state_e               state_q;
    logic [AW-1:0]        pc_q;
    logic [STEP_BITS-1:0] pre_q;
    logic [ARG_W-1:0]     steps_q;    // steps left in the current WAIT/RST entry
    logic                 first_q;    // first cycle after reset release
    logic                 sys_n_reset_q;
    logic [NUM_KEYS-1:0]  keys_q;
    logic                 busy_q;
    logic                 done_q;

    logic [1:0]           op;
    logic [ARG_W-1:0]     arg;
    logic [NUM_KEYS-1:0]  key_onehot;
    logic                 step_end;
    logic                 entry_done;
    logic                 run_end;

    // Power-up contents: all END.
    initial begin
        for (int i = 0; i < int'(SCRIPT_LEN); i++) mem_q[i] = '0;
    end

    // Write port is independent of reset and FSM state. A write to the entry being fetched
    // lands at the decode edge, so that decode still sees the old entry.
    always_ff @(posedge clk_i) begin
        if (script_we_i) mem_q[script_addr_i] <= script_data_i;
    end

    assign op       = mem_q[pc_q][ARG_W+1:ARG_W];
    assign arg      = mem_q[pc_q][ARG_W-1:0];
    assign step_end = &pre_q;

    // Out-of-range key index decodes to all zeros.
    always_comb begin
        key_onehot = '0;
        for (int k = 0; k < int'(NUM_KEYS); k++) begin
            if (arg == ARG_W'(k)) key_onehot[k] = 1'b1;
        end
    end

    always_comb begin
        entry_done = 1'b0;
        run_end    = 1'b0;
        case (state_q)
            StFetch: begin
                run_end    = (op == OpEnd);
                entry_done = (op == OpWait) && (arg == '0);
            end
            StPressGap:    entry_done = step_end;
            StWait, StRst: entry_done = step_end && (steps_q == ARG_W'(1));
            default: ;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!n_reset_i) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            pre_q         <= '0;
            steps_q       <= '0;
            first_q       <= 1'b1;
            sys_n_reset_q <= 1'b0;
            keys_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else if (abort_i) begin
            state_q       <= StIdle;
            pc_q          <= '0;
            pre_q         <= '0;
            first_q       <= 1'b0;
            sys_n_reset_q <= 1'b1;
            keys_q        <= '0;
            busy_q        <= 1'b0;
            done_q        <= 1'b0;
        end else begin
            first_q       <= 1'b0;
            pre_q         <= pre_q + STEP_BITS'(1);
            sys_n_reset_q <= 1'b1;
`ifdef AUTOTYPE_LOOP_EN
            done_q        <= 1'b0;
`endif
            case (state_q)
                StIdle, StDone: begin
                    if (start_i || (state_q == StIdle && AUTOSTART && first_q)) begin
                        state_q <= StFetch;
                        pc_q    <= '0;
                        busy_q  <= 1'b1;
                        done_q  <= 1'b0;
                    end
                end
                StFetch: begin
                    pre_q <= '0;
                    unique case (op)
                        OpPress: begin
                            keys_q  <= key_onehot;
                            state_q <= StPressHold;
                        end
                        OpWait: begin
                            steps_q <= arg;
                            if (arg != '0) state_q <= StWait;
                        end
                        OpReset: begin
                            steps_q       <= (arg == '0) ? ARG_W'(1) : arg;
                            sys_n_reset_q <= 1'b0;
                            state_q       <= StRst;
                        end
                        default: ;
                    endcase
                end
                StPressHold: begin
                    if (step_end) begin
                        keys_q  <= '0;
                        state_q <= StPressGap;
                    end
                end
                StPressGap: ;
                StWait: begin
                    if (step_end) steps_q <= steps_q - ARG_W'(1);
                end
                StRst: begin
                    if (step_end) steps_q <= steps_q - ARG_W'(1);
                    if (!(step_end && steps_q == ARG_W'(1))) sys_n_reset_q <= 1'b0;
                end
                default: state_q <= StIdle;
            endcase

            // Entry complete: advance, or finish after END / the last entry (pc never wraps
            // in one-shot mode).
            if (run_end || entry_done) begin
                if (run_end || pc_q == LastPc) begin
                    pc_q    <= '0;
                    done_q  <= 1'b1;
`ifdef AUTOTYPE_LOOP_EN
                    state_q <= StFetch;
`else
                    state_q <= StDone;
                    busy_q  <= 1'b0;
`endif
                end else begin
                    pc_q    <= pc_q + AW'(1);
                    state_q <= StFetch;
                end
            end
        end
    end

    assign sys_n_reset_o = sys_n_reset_q;
    assign keys_o        = keys_q;
    assign busy_o        = busy_q;
    assign done_o        = done_q;

endmodule
